// File: rtl/ysyx_23060236_axi_sram.sv
// ysyx_23060236_axi_sram: single-outstanding AXI4 slave SRAM with programmable read latency,
// INCR/FIXED bursts, byte-strobed writes and DECERR/SLVERR responses.
module ysyx_23060236_axi_sram #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          RD_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        awready,
    input  logic        awvalid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    output logic        wready,
    input  logic        wvalid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        bready,
    output logic        bvalid,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    output logic        arready,
    input  logic        arvalid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        rready,
    output logic        rvalid,
    output logic [1:0]  rresp,
    output logic [31:0] rdata,
    output logic        rlast,
    output logic [3:0]  rid
);
    localparam int CW = RD_LATENCY > 1 ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, R_WAIT, R_DATA, W_DATA, W_RESP} state_t;

    state_t                state;
    logic                  prio_w;
    logic [31:0]           mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] idx, nidx;
    logic [7:0]            len, beat;
    logic                  fixed, wl_err, last;
    logic [1:0]            err, aerr, werr;
    logic [3:0]            id;
    logic [CW-1:0]         cnt;
    logic [31:0]           aoff, woff;
    logic                  ar_hs, aw_hs, w_hs;
    logic                  unused_ok;

    // With both address channels valid only the channel named by prio_w sees ready.
    assign arready = !reset && state == IDLE && (!awvalid || !prio_w);
    assign awready = !reset && state == IDLE && (!arvalid || prio_w);
    assign ar_hs   = arvalid && arready;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign aoff    = araddr - BASE_ADDR;
    assign woff    = awaddr - BASE_ADDR;
    assign aerr    = |aoff[31:DEPTH_LOG2+2] ? 2'b11 : arburst[1] ? 2'b10 : 2'b00;
    assign werr    = |woff[31:DEPTH_LOG2+2] ? 2'b11 : awburst[1] ? 2'b10 : 2'b00;
    assign nidx    = fixed ? idx : idx + DEPTH_LOG2'(1);
    assign last    = beat == len;
    assign unused_ok = ^{arsize, awsize, aoff[1:0], woff[1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            prio_w <= 1'b0;
            wready <= 1'b0;
            bvalid <= 1'b0;
            bresp  <= 2'b00;
            bid    <= 4'd0;
            rvalid <= 1'b0;
            rresp  <= 2'b00;
            rdata  <= 32'd0;
            rlast  <= 1'b0;
            rid    <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ar_hs) begin
                        state  <= R_WAIT;
                        prio_w <= !prio_w;
                        idx    <= aoff[DEPTH_LOG2+1:2];
                        len    <= arlen;
                        beat   <= 8'd0;
                        fixed  <= arburst == 2'b00;
                        err    <= aerr;
                        id     <= arid;
                        cnt    <= CW'(RD_LATENCY - 1);
                    end else if (aw_hs) begin
                        state  <= W_DATA;
                        prio_w <= !prio_w;
                        wready <= 1'b1;
                        idx    <= woff[DEPTH_LOG2+1:2];
                        len    <= awlen;
                        beat   <= 8'd0;
                        fixed  <= awburst == 2'b00;
                        err    <= werr;
                        id     <= awid;
                        wl_err <= 1'b0;
                    end
                end
                R_WAIT: begin
                    if (cnt == '0) begin
                        state  <= R_DATA;
                        rvalid <= 1'b1;
                        rdata  <= |err ? 32'd0 : mem[idx];
                        rresp  <= err;
                        rid    <= id;
                        rlast  <= last;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (last) begin
                            state  <= IDLE;
                            rvalid <= 1'b0;
                            rlast  <= 1'b0;
                        end else begin
                            beat  <= beat + 8'd1;
                            idx   <= nidx;
                            rdata <= |err ? 32'd0 : mem[nidx];
                            rlast <= beat + 8'd1 == len;
                        end
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (last) begin
                            state  <= W_RESP;
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bid    <= id;
                            bresp  <= |err ? err : (wl_err || !wlast) ? 2'b10 : 2'b00;
                        end else begin
                            beat   <= beat + 8'd1;
                            idx    <= nidx;
                            wl_err <= wl_err || wlast;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        state  <= IDLE;
                        bvalid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset; errored bursts never touch it.
    always_ff @(posedge clock) begin
        if (!reset && state == W_DATA && w_hs && err == 2'b00)
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
endmodule

// File: tb/tb_ysyx_23060236_axi_sram.sv
// tb_ysyx_23060236_axi_sram: randomized AXI traffic against a word-array reference model;
// expected R beats and B responses are queued at issue and checked by an independent monitor.
module tb_ysyx_23060236_axi_sram;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          WORDS = 4096;
    localparam int          LAT   = 2;

    logic        clock = 1'b0, reset = 1'b1;
    logic        awready, awvalid, wready, wvalid, wlast, bready, bvalid;
    logic        arready, arvalid, rready, rvalid, rlast;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  awid, arid, bid, rid, wstrb;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;

    always #5 clock = ~clock;

    ysyx_23060236_axi_sram #(.DEPTH_LOG2(12), .BASE_ADDR(BASE), .RD_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bready(bready), .bvalid(bvalid), .bresp(bresp), .bid(bid),
        .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
        logic [3:0]  id;
        logic        l;
    } rbeat_t;

    rbeat_t      rq[$];
    logic [5:0]  bq[$];
    bit   [31:0] mdl [WORDS];
    logic [31:0] wdq[$];
    logic [3:0]  wsq[$];
    logic [31:0] grants = 0;
    int          n_chk = 0, n_fail = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tmo(string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out", nm);
    endtask

    function automatic logic [1:0] resp_of(logic [31:0] addr, logic [1:0] burst);
        longint off = longint'(addr) - longint'(BASE);
        return (off < 0 || off >= 4 * WORDS) ? 2'b11 : burst >= 2'd2 ? 2'b10 : 2'b00;
    endfunction

    function automatic int word_of(logic [31:0] addr, logic [1:0] burst, int i);
        longint off = longint'(addr) - longint'(BASE);
        return int'((off / 4 + (burst == 2'b00 ? 0 : i)) % WORDS);
    endfunction

    // Monitor: pops the scoreboard on every R/B handshake and checks stall stability.
    rbeat_t cur, held, e;
    logic   stalled = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            cur = {rdata, rresp, rid, rlast};
            if (stalled) chk("r_hold", {rvalid, cur}, {1'b1, held});
            stalled = rvalid && !rready;
            held = cur;
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL r_unexpected: got beat %h with no expected beat", cur);
                end else begin
                    e = rq.pop_front();
                    chk("r_beat", cur, e);
                end
            end
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL b_unexpected: got resp %0d id %0d with none expected", bresp, bid);
                end else begin
                    chk("b_resp", {bresp, bid}, bq.pop_front());
                end
            end
            if (arvalid && arready) grants = {grants[29:0], 2'b01};
            if (awvalid && awready) grants = {grants[29:0], 2'b10};
        end
    end

    task automatic do_read(logic [31:0] addr, logic [3:0] id, logic [7:0] len, logic [1:0] burst, int mode);
        logic [1:0] er;
        bit         done;
        int         k, cyc;
        rbeat_t     b;
        er = resp_of(addr, burst);
        rready = 1'b0;
        arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arburst = burst;
        arsize = 3'($urandom_range(0, 2));
        k = 0;
        do begin
            @(negedge clock); done = arready; @(posedge clock); #1; k++;
        end while (!done && k < 200);
        arvalid = 1'b0;
        if (!done) begin tmo("ar_handshake"); return; end
        for (int i = 0; i <= int'(len); i++) begin
            b.d = er != 2'b00 ? 32'd0 : mdl[word_of(addr, burst, i)];
            b.r = er;
            b.id = id;
            b.l = i == int'(len);
            rq.push_back(b);
        end
        k = 0;
        @(negedge clock);
        while (!rvalid && k < 100) begin k++; @(negedge clock); end
        chk("r_latency", k, LAT);
        cyc = 0;
        done = 0;
        while (!done && cyc < 2000) begin
            @(posedge clock); #1;
            rready = mode == 0 ? 1'b1 : mode == 1 ? !cyc[0] : 1'($urandom_range(0, 1));
            @(negedge clock);
            done = rvalid && rready && rlast;
            cyc++;
        end
        @(posedge clock); #1;
        rready = 1'b0;
        if (!done) tmo("r_burst");
    endtask

    task automatic do_write(logic [31:0] addr, logic [3:0] id, logic [7:0] len, logic [1:0] burst, int bad);
        logic [1:0]  er;
        logic [31:0] d;
        logic [3:0]  s;
        bit          done;
        int          k, w;
        er = resp_of(addr, burst);
        awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awburst = burst;
        awsize = 3'($urandom_range(0, 2));
        k = 0;
        do begin
            @(negedge clock); done = awready; @(posedge clock); #1; k++;
        end while (!done && k < 200);
        awvalid = 1'b0;
        if (!done) begin tmo("aw_handshake"); return; end
        for (int i = 0; i <= int'(len); i++) begin
            d = wdq.size() != 0 ? wdq.pop_front() : $urandom;
            s = wsq.size() != 0 ? wsq.pop_front() : 4'($urandom);
            if (er == 2'b00) begin
                w = word_of(addr, burst, i);
                for (int j = 0; j < 4; j++) if (s[j]) mdl[w][8*j +: 8] = d[8*j +: 8];
            end
            if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
            wvalid = 1'b1; wdata = d; wstrb = s; wlast = (i == int'(len)) ^ (i == bad);
            k = 0;
            do begin
                @(negedge clock); done = wready; @(posedge clock); #1; k++;
            end while (!done && k < 200);
            wvalid = 1'b0;
            if (!done) begin tmo("w_beat"); return; end
        end
        bq.push_back({er != 2'b00 ? er : (bad >= 0 && bad <= int'(len)) ? 2'b10 : 2'b00, id});
        repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
        bready = 1'b1;
        k = 0;
        do begin
            @(negedge clock); done = bvalid; @(posedge clock); #1; k++;
        end while (!done && k < 200);
        bready = 1'b0;
        if (!done) tmo("b_wait");
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] a;
        logic [1:0]  bu;
        logic [7:0]  ln;
        int          k;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_awready", awready, 0);
        chk("rst_rdata", {rdata, rresp, rid, rlast}, 0);
        chk("rst_bresp", {bresp, bid}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("idle_ready", {arready, awready}, 2'b11);
        @(posedge clock); #1;

        // Single write then readback
        wdq.push_back(32'hDEAD_BEEF); wsq.push_back(4'hF);
        do_write(32'h8000_0010, 4'd3, 8'd0, 2'b01, -1);
        do_read(32'h8000_0010, 4'd5, 8'd0, 2'b01, 0);

        // Byte strobes over a preloaded word
        wdq.push_back(32'h1122_3344); wsq.push_back(4'hF);
        do_write(32'h8000_0020, 4'd1, 8'd0, 2'b01, -1);
        wdq.push_back(32'hAABB_CCDD); wsq.push_back(4'b0101);
        do_write(32'h8000_0020, 4'd1, 8'd0, 2'b01, -1);
        do_read(32'h8000_0020, 4'd2, 8'd0, 2'b01, 0);
        chk("strobe_model", mdl[8], 32'h11BB_33DD);

        // Preload words 0..79, then an IFU-style burst with rready toggling
        repeat (80) wsq.push_back(4'hF);
        do_write(BASE, 4'd1, 8'd79, 2'b01, -1);
        do_read(BASE, 4'd2, 8'd3, 2'b01, 1);

        // Error responses
        do_read(32'h2000_0000, 4'd7, 8'd1, 2'b01, 0);
        do_read(BASE + 32'd8, 4'd7, 8'd0, 2'b10, 0);
        do_read(BASE + 32'd8, 4'd6, 8'd2, 2'b11, 2);
        do_write(BASE + 32'd12, 4'd4, 8'd1, 2'b01, 0);
        do_read(BASE + 32'd12, 4'd4, 8'd1, 2'b01, 0);
        do_write(BASE + 32'd16, 4'd4, 8'd1, 2'b01, 1);
        do_write(32'h9000_0000, 4'd6, 8'd2, 2'b01, -1);
        do_write(32'h7FFF_FFFC, 4'd6, 8'd0, 2'b01, -1);
        do_write(BASE + 32'd4, 4'd6, 8'd1, 2'b10, -1);
        do_read(BASE, 4'd3, 8'd7, 2'b01, 2);

        // FIXED bursts, unaligned start, and index wrap at the top of the array
        do_write(BASE + 32'd40, 4'd1, 8'd3, 2'b00, -1);
        do_read(BASE + 32'd40, 4'd1, 8'd3, 2'b00, 2);
        wsq.push_back(4'hF); wsq.push_back(4'hF);
        do_write(BASE + 32'h3FFC, 4'd2, 8'd1, 2'b01, -1);
        do_read(BASE + 32'h3FFC, 4'd2, 8'd2, 2'b01, 2);
        do_read(BASE + 32'd21, 4'd8, 8'd1, 2'b01, 0);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            a  = BASE + 4 * $urandom_range(0, 63) + $urandom_range(0, 3);
            bu = $urandom_range(0, 9) == 0 ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            ln = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = $urandom_range(0, 1) != 0 ? 32'h4000_0000 : 32'h8001_0000;
            if ($urandom_range(0, 1) != 0)
                do_read(a, 4'($urandom), ln, bu, 2);
            else
                do_write(a, 4'($urandom), ln, bu, $urandom_range(0, 5) == 0 ? int'($urandom_range(0, ln)) : -1);
        end

        // Reset while beat 2 of 4 is stalled
        for (int i = 0; i < 4; i++) rq.push_back({mdl[i], 2'b00, 4'd9, i == 3});
        arvalid = 1'b1; araddr = BASE; arid = 4'd9; arlen = 8'd3; arburst = 2'b01;
        k = 0;
        do begin
            @(negedge clock); a[0] = arready; @(posedge clock); #1; k++;
        end while (!a[0] && k < 200);
        arvalid = 1'b0;
        if (!a[0]) tmo("rst_ar_handshake");
        k = 0;
        @(negedge clock);
        while (!rvalid && k < 100) begin k++; @(negedge clock); end
        @(posedge clock); #1; rready = 1'b1;
        @(negedge clock);
        @(posedge clock); #1; rready = 1'b0;
        @(negedge clock);
        chk("rst_pre_beat2", {rvalid, rlast}, 2'b10);
        @(posedge clock); #1; reset = 1'b1;
        rq.delete();
        @(posedge clock); #1; reset = 1'b0;
        @(negedge clock);
        chk("rst_mid_rvalid", rvalid, 0);
        chk("rst_mid_idle", {arready, awready, wready, bvalid}, 4'b1100);
        chk("rst_mid_rdata", {rdata, rlast, rid}, 0);
        @(posedge clock); #1;

        // Arbitration after reset: read first, then write, then read
        grants = 0;
        fork
            begin
                do_read(BASE + 32'd4, 4'd1, 8'd1, 2'b01, 0);
                do_read(BASE + 32'd8, 4'd2, 8'd1, 2'b01, 0);
            end
            do_write(BASE + 32'd8, 4'd3, 8'd1, 2'b01, -1);
        join
        chk("arb_order", grants, 32'h19);
        do_read(BASE + 32'd8, 4'd3, 8'd3, 2'b01, 2);

        repeat (4) @(posedge clock);
        chk("rq_empty", rq.size(), 0);
        chk("bq_empty", bq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
